// File: rtl/edge_binarize_pack.sv
// Thresholds Sobel magnitudes to edge flags and packs them LSB-first into words.
// Optional EDGE_PACK_STATS_EN adds a per-frame edge_count output.
module edge_binarize_pack #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 720,
  parameter int IMAGE_HEIGHT = 540,
  parameter int PACK_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic                  input_empty,
  input  logic [DATA_WIDTH-1:0] edge_in,
  output logic                  read_fifo,
  input  logic                  output_full,
  output logic                  write_fifo,
  output logic [PACK_WIDTH-1:0] packed_out,
  output logic                  frame_done
`ifdef EDGE_PACK_STATS_EN
  ,
  output logic [$clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1)-1:0] edge_count
`endif
);

  localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int PW = $clog2(PACK_WIDTH);
  localparam logic [CW-1:0] COL_MAX = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMAGE_HEIGHT - 1);
  localparam logic [PW-1:0] BIT_MAX = PW'(PACK_WIDTH - 1);

  typedef enum logic [1:0] {
    S_READ,
    S_SAMPLE,
    S_WRITE
  } state_t;

  state_t                  state;
  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic [PW-1:0]           bit_idx;
  logic [PACK_WIDTH-1:0]   pack;
  logic [DATA_WIDTH-1:0]   thr_q;
  logic [DATA_WIDTH-1:0]   thr_use;
  logic                    last_word;
  logic                    first_px;
  logic                    flag;
  logic                    col_end;
  logic                    row_end;

  assign first_px = (col == '0) && (row == '0);
  // First pixel of a frame compares against the live threshold
  assign thr_use  = first_px ? threshold : thr_q;
  assign flag     = edge_in >= thr_use;
  assign col_end  = col == COL_MAX;
  assign row_end  = row == ROW_MAX;

  assign read_fifo  = !rst && (state == S_READ) && !input_empty;
  assign write_fifo = !rst && (state == S_WRITE) && !output_full;
  assign packed_out = pack;
  assign frame_done = write_fifo && last_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_READ;
      col       <= '0;
      row       <= '0;
      bit_idx   <= '0;
      pack      <= '0;
      thr_q     <= '0;
      last_word <= 1'b0;
    end else begin
      unique case (state)
        S_READ: begin
          if (!input_empty) state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          if (first_px) thr_q <= threshold;
          pack[bit_idx] <= flag;
          last_word     <= col_end && row_end;
          if (bit_idx == BIT_MAX || col_end) state <= S_WRITE;
          else state <= S_READ;
          // A word never spans rows, so the bit index restarts with the row
          bit_idx <= col_end ? '0 : bit_idx + PW'(1);
          if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        S_WRITE: begin
          if (!output_full) begin
            pack  <= '0;
            state <= S_READ;
          end
        end
        default: state <= S_READ;
      endcase
    end
  end

`ifdef EDGE_PACK_STATS_EN
  localparam int SW = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1);
  logic [SW-1:0] edge_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt   <= '0;
      edge_count <= '0;
    end else begin
      if (state == S_SAMPLE) begin
        if (first_px) edge_cnt <= SW'(flag);
        else edge_cnt <= edge_cnt + SW'(flag);
      end
      // Last sample already folded in by the time the final word is written
      if (frame_done) edge_count <= edge_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_edge_binarize_pack.sv
// Directed bench for edge_binarize_pack on a 10x2 image with 8-bit packing.
// Models the upstream FIFO with registered read and captures downstream writes.
module tb_edge_binarize_pack;

  localparam int DW = 8;
  localparam int IW = 10;
  localparam int IH = 2;
  localparam int PW = 8;

  logic          clk = 0;
  logic          rst = 1;
  logic [DW-1:0] threshold = '0;
  logic          input_empty;
  logic [DW-1:0] edge_in = '0;
  logic          read_fifo;
  logic          output_full = 0;
  logic          write_fifo;
  logic [PW-1:0] packed_out;
  logic          frame_done;
`ifdef EDGE_PACK_STATS_EN
  logic [$clog2(IW*IH+1)-1:0] edge_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] src_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic stall = 0;
  logic stall_en = 0;

  logic [PW-1:0] out_word [0:63];
  logic          out_fd   [0:63];
  int out_cnt = 0;
  logic overlap = 0;

  always #5 clk = ~clk;

  edge_binarize_pack #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(IW),
    .IMAGE_HEIGHT(IH), .PACK_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst), .threshold(threshold),
    .input_empty(input_empty), .edge_in(edge_in),
    .read_fifo(read_fifo), .output_full(output_full),
    .write_fifo(write_fifo), .packed_out(packed_out),
    .frame_done(frame_done)
`ifdef EDGE_PACK_STATS_EN
    , .edge_count(edge_count)
`endif
  );

  assign input_empty = (wr_ptr == rd_ptr) || stall;

  always @(posedge clk) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
    end else if (read_fifo) begin
      edge_in <= src_mem[rd_ptr % 64];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  always @(posedge clk) begin
    if (write_fifo) begin
      out_word[out_cnt % 64] <= packed_out;
      out_fd[out_cnt % 64]   <= frame_done;
      out_cnt <= out_cnt + 1;
    end
    if (read_fifo && write_fifo) overlap <= 1'b1;
  end

  always @(negedge clk)
    stall <= stall_en ? 1'($urandom_range(0, 1)) : 1'b0;

  task automatic push(input logic [DW-1:0] pix);
    src_mem[wr_ptr % 64] = pix;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_n(input logic [DW-1:0] pix, input int n);
    for (int i = 0; i < n; i++) push(pix);
  endtask

  task automatic wait_words(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (out_cnt >= target) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_pops(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rd_ptr >= target) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({read_fifo, write_fifo, frame_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 000",
               {read_fifo, write_fifo, frame_done});
    end
    checks++;
    if (packed_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_packed: got %h want 00", packed_out);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if ({read_fifo, write_fifo, frame_done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_strobes: got %b want 000",
               {read_fifo, write_fifo, frame_done});
    end
  endtask

  task automatic test_basic_pack;
    logic [PW-1:0] exp [4];
    int base;
    bit ok;
    exp = '{8'hDA, 8'h01, 8'hFF, 8'h03};
    base = out_cnt;
    threshold = 8'd100;
    push(0); push(100); push(99); push(255);
    push(101); push(50); push(200); push(100);
    push(255); push(0);
    push_n(255, 10);
    wait_words(base + 4, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: got %0d words want 4", out_cnt - base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_word[base+i] !== exp[i]) begin
        errors++;
        $display("FAIL basic_word%0d: got %h want %h", i,
                 out_word[base+i], exp[i]);
      end
      checks++;
      if (out_fd[base+i] !== (i == 3)) begin
        errors++;
        $display("FAIL basic_fd%0d: got %b want %b", i,
                 out_fd[base+i], (i == 3));
      end
    end
`ifdef EDGE_PACK_STATS_EN
    checks++;
    if (edge_count !== 16) begin
      errors++;
      $display("FAIL stats_count: got %0d want 16", edge_count);
    end
`endif
  endtask

  task automatic test_padding;
    logic [PW-1:0] exp [4];
    int base;
    bit ok;
    exp = '{8'hFF, 8'h03, 8'hFF, 8'h03};
    base = out_cnt;
    threshold = 8'd1;
    push_n(255, 20);
    wait_words(base + 4, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok || out_cnt !== base + 4) begin
      errors++;
      $display("FAIL pad_count: got %0d words want 4", out_cnt - base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_word[base+i] !== exp[i] || out_fd[base+i] !== (i == 3)) begin
        errors++;
        $display("FAIL pad_word%0d: got %h/%b want %h/%b", i,
                 out_word[base+i], out_fd[base+i], exp[i], (i == 3));
      end
    end
  endtask

  task automatic test_threshold_bounds;
    logic [PW-1:0] exp [8];
    int base;
    bit ok;
    exp = '{8'hFF, 8'h03, 8'hFF, 8'h03, 8'h55, 8'h01, 8'h55, 8'h01};
    base = out_cnt;
    threshold = 8'd0;
    push_n(0, 20);
    wait_words(base + 4, ok);
    threshold = 8'd255;
    for (int i = 0; i < 20; i++) push((i % 2 == 0) ? 8'd255 : 8'd254);
    wait_words(base + 8, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bounds_timeout: got %0d words want 8", out_cnt - base);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_word[base+i] !== exp[i] || out_fd[base+i] !== (i % 4 == 3)) begin
        errors++;
        $display("FAIL bounds_word%0d: got %h/%b want %h/%b", i,
                 out_word[base+i], out_fd[base+i], exp[i], (i % 4 == 3));
      end
    end
  endtask

  task automatic test_backpressure;
    logic [PW-1:0] exp [4];
    int base;
    int start;
    bit ok;
    exp = '{8'hFD, 8'h03, 8'hFF, 8'h03};
    base = out_cnt;
    start = rd_ptr;
    threshold = 8'd1;
    output_full = 1;
    push(255); push(0);
    push_n(255, 8);
    repeat (30) @(negedge clk);
    checks++;
    if (rd_ptr !== start + 8) begin
      errors++;
      $display("FAIL bp_pops: got %0d want 8", rd_ptr - start);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({write_fifo, read_fifo} !== 2'b00 || packed_out !== exp[0]) begin
        errors++;
        $display("FAIL bp_stall%0d: got w%b r%b %h want w0 r0 %h", i,
                 write_fifo, read_fifo, packed_out, exp[0]);
      end
      @(negedge clk);
    end
    output_full = 0;
    @(negedge clk);
    checks++;
    if (out_cnt !== base + 1 || out_word[base] !== exp[0]) begin
      errors++;
      $display("FAIL bp_release: got %0d words %h want 1 word %h",
               out_cnt - base, out_word[base], exp[0]);
    end
    push_n(255, 10);
    wait_words(base + 4, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok || out_cnt !== base + 4) begin
      errors++;
      $display("FAIL bp_count: got %0d words want 4", out_cnt - base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_word[base+i] !== exp[i] || out_fd[base+i] !== (i == 3)) begin
        errors++;
        $display("FAIL bp_word%0d: got %h/%b want %h/%b", i,
                 out_word[base+i], out_fd[base+i], exp[i], (i == 3));
      end
    end
  endtask

  task automatic test_threshold_latch;
    logic [PW-1:0] exp [8];
    logic [DW-1:0] row0 [10];
    int base;
    int start;
    bit ok;
    exp = '{8'hFF, 8'h01, 8'hFF, 8'h03, 8'h8D, 8'h01, 8'h00, 8'h00};
    row0 = '{250, 100, 250, 250, 100, 100, 100, 250, 250, 100};
    base = out_cnt;
    stall_en = 1;
    threshold = 8'd10;
    start = rd_ptr;
    push_n(100, 9); push(5);
    push_n(100, 10);
    wait_pops(start + 3, ok);
    threshold = 8'd200;
    wait_words(base + 4, ok);
    start = rd_ptr;
    for (int i = 0; i < 10; i++) push(row0[i]);
    push_n(100, 10);
    wait_pops(start + 3, ok);
    threshold = 8'd10;
    wait_words(base + 8, ok);
    stall_en = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL latch_timeout: got %0d words want 8", out_cnt - base);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_word[base+i] !== exp[i] || out_fd[base+i] !== (i % 4 == 3)) begin
        errors++;
        $display("FAIL latch_word%0d: got %h/%b want %h/%b", i,
                 out_word[base+i], out_fd[base+i], exp[i], (i % 4 == 3));
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [PW-1:0] exp [4];
    int base;
    int start;
    bit ok;
    exp = '{8'hDA, 8'h01, 8'hFF, 8'h03};
    base = out_cnt;
    start = rd_ptr;
    threshold = 8'd1;
    push_n(255, 5);
    wait_pops(start + 5, ok);
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++;
    if (out_cnt !== base) begin
      errors++;
      $display("FAIL rst_partial: got %0d words want 0", out_cnt - base);
    end
    threshold = 8'd100;
    push(0); push(100); push(99); push(255);
    push(101); push(50); push(200); push(100);
    push(255); push(0);
    push_n(255, 10);
    wait_words(base + 4, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_timeout: got %0d words want 4", out_cnt - base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_word[base+i] !== exp[i] || out_fd[base+i] !== (i == 3)) begin
        errors++;
        $display("FAIL rst_word%0d: got %h/%b want %h/%b", i,
                 out_word[base+i], out_fd[base+i], exp[i], (i == 3));
      end
    end
  endtask

  task automatic test_no_overlap;
    checks++;
    if (overlap !== 1'b0) begin
      errors++;
      $display("FAIL rw_overlap: got %b want 0", overlap);
    end
  endtask

  initial begin
    test_reset;
    test_basic_pack;
    test_padding;
    test_threshold_bounds;
    test_backpressure;
    test_threshold_latch;
    test_reset_mid;
    test_no_overlap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
